regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a single register-file write port.
// Two producers (ALU on port A, memory loads on port B) each own a
// one-entry holding buffer. A round-robin grant picks one full buffer per
// cycle, and that buffer's entry is registered onto the write outputs.
//
// Handshake: a request on port X transfers at a rising edge where
// x_valid & x_ready are both high. x_ready depends only on internal state:
// it is high when the buffer is empty or is being drained this cycle.
// A request to register 0 is accepted and dropped, because r0 is never
// written.
module regfile_wb_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_reg,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_reg,
    input  logic [31:0]      b_data,
    output logic             ctrl_writeEnable,
    output logic [4:0]       ctrl_writeReg,
    output logic [31:0]      data_writeReg,
    output logic             idle,
    output logic [CNT_W-1:0] conflicts
);

    logic             full_a_q, full_a_d;
    logic [4:0]       reg_a_q, reg_a_d;
    logic [31:0]      data_a_q, data_a_d;
    logic             full_b_q, full_b_d;
    logic [4:0]       reg_b_q, reg_b_d;
    logic [31:0]      data_b_q, data_b_d;
    logic             last_b_q, last_b_d;
    logic             we_q, we_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic grant_a, grant_b;
    logic acc_a, acc_b;

    // Grant: a lone full buffer wins; on contention the port not granted last wins.
    always_comb begin
        grant_a = full_a_q & (~full_b_q | last_b_q);
        grant_b = full_b_q & (~full_a_q | ~last_b_q);
        a_ready = ~full_a_q | grant_a;
        b_ready = ~full_b_q | grant_b;
        acc_a   = a_valid & a_ready & (a_reg != 5'd0);
        acc_b   = b_valid & b_ready & (b_reg != 5'd0);
    end

    // Next state: buffers refill on accept, drain on grant; the granted entry goes to the write port.
    always_comb begin
        full_a_d = acc_a ? 1'b1 : (grant_a ? 1'b0 : full_a_q);
        reg_a_d  = acc_a ? a_reg  : reg_a_q;
        data_a_d = acc_a ? a_data : data_a_q;
        full_b_d = acc_b ? 1'b1 : (grant_b ? 1'b0 : full_b_q);
        reg_b_d  = acc_b ? b_reg  : reg_b_q;
        data_b_d = acc_b ? b_data : data_b_q;

        last_b_d = last_b_q;
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        if (grant_a) begin
            last_b_d = 1'b0;
            we_d     = 1'b1;
            wreg_d   = reg_a_q;
            wdata_d  = data_a_q;
        end else if (grant_b) begin
            last_b_d = 1'b1;
            we_d     = 1'b1;
            wreg_d   = reg_b_q;
            wdata_d  = data_b_q;
        end

        cnt_d = cnt_q;
        if (full_a_q && full_b_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register; reset empties both buffers and points priority at A.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            full_a_q <= 1'b0;
            reg_a_q  <= 5'd0;
            data_a_q <= 32'd0;
            full_b_q <= 1'b0;
            reg_b_q  <= 5'd0;
            data_b_q <= 32'd0;
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            wreg_q   <= 5'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= '0;
        end else begin
            full_a_q <= full_a_d;
            reg_a_q  <= reg_a_d;
            data_a_q <= data_a_d;
            full_b_q <= full_b_d;
            reg_b_q  <= reg_b_d;
            data_b_q <= data_b_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Output mapping.
    always_comb begin
        ctrl_writeEnable = we_q;
        ctrl_writeReg    = wreg_q;
        data_writeReg    = wdata_q;
        conflicts        = cnt_q;
        idle             = ~full_a_q & ~full_b_q & ~we_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model of the arbitration rules.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready, s_a_ready, s_b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        we, s_we;
  logic [4:0]  wreg, s_wreg;
  logic [31:0] wdata, s_wdata;
  logic        idle, s_idle;
  logic [7:0]  conflicts;
  logic [1:0]  s_conflicts;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.CNT_W(8)) u_dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
    .idle(idle), .conflicts(conflicts)
  );

  regfile_wb_arbiter #(.CNT_W(2)) u_sat (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_reg(b_reg), .b_data(b_data),
    .ctrl_writeEnable(s_we), .ctrl_writeReg(s_wreg), .data_writeReg(s_wdata),
    .idle(s_idle), .conflicts(s_conflicts)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
  endtask

  // Called at posedge+1; leaves the block out of reset at posedge+4.
  task automatic do_reset();
    idle_inputs();
    ctrl_reset = 0;
    #3;
    ctrl_reset = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    ctrl_reset = 0;
    #2;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0h want 0", we); end
    n_checks++; if (wreg !== 5'd0) begin n_fail++; $display("FAIL rst_wreg: got %0h want 0", wreg); end
    n_checks++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %0h want 0", wdata); end
    n_checks++; if (conflicts !== 8'd0) begin n_fail++; $display("FAIL rst_conflicts: got %0h want 0", conflicts); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %0h want 1", idle); end
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0h%0h want 11", a_ready, b_ready); end
    // requests presented while in reset must not be taken
    a_valid = 1; a_reg = 5'd7; a_data = 32'h77;
    b_valid = 1; b_reg = 5'd8; b_data = 32'h88;
    tick();
    tick();
    n_checks++; if (we !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rst_hold: got we=%0h idle=%0h want we=0 idle=1", we, idle); end
    idle_inputs();
    ctrl_reset = 1;
    tick();
    n_checks++; if (idle !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL rst_release_idle: got idle=%0h we=%0h want idle=1 we=0", idle, we); end
  endtask

  task automatic test_single_write();
    do_reset();
    a_valid = 1; a_reg = 5'd5; a_data = 32'h0000_1234;
    tick();
    idle_inputs();
    n_checks++; if (we !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL single_accept: got we=%0h idle=%0h want we=0 idle=0", we, idle); end
    tick();
    n_checks++; if (we !== 1'b1 || wreg !== 5'd5 || wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL single_write: got we=%0h reg=%0d data=%0h want 1/5/1234", we, wreg, wdata); end
    tick();
    n_checks++; if (we !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL single_after: got we=%0h idle=%0h want we=0 idle=1", we, idle); end
    n_checks++; if (wreg !== 5'd5 || wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL single_hold: got reg=%0d data=%0h want 5/1234", wreg, wdata); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    a_valid = 1; a_reg = 5'd3; a_data = 32'hA;
    b_valid = 1; b_reg = 5'd4; b_data = 32'hB;
    tick();
    idle_inputs();
    n_checks++; if (b_ready !== 1'b0 || a_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got a=%0h b=%0h want a=1 b=0", a_ready, b_ready); end
    tick();
    n_checks++; if (we !== 1'b1 || wreg !== 5'd3 || wdata !== 32'hA) begin n_fail++; $display("FAIL simul_first: got we=%0h reg=%0d data=%0h want 1/3/a", we, wreg, wdata); end
    n_checks++; if (conflicts !== 8'd1) begin n_fail++; $display("FAIL simul_conflicts: got %0d want 1", conflicts); end
    tick();
    n_checks++; if (we !== 1'b1 || wreg !== 5'd4 || wdata !== 32'hB) begin n_fail++; $display("FAIL simul_second: got we=%0h reg=%0d data=%0h want 1/4/b", we, wreg, wdata); end
    tick();
    n_checks++; if (we !== 1'b0 || idle !== 1'b1 || conflicts !== 8'd1) begin n_fail++; $display("FAIL simul_end: got we=%0h idle=%0h cnt=%0d want 0/1/1", we, idle, conflicts); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_q[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] next_a, next_b;
    int n_acc_a, n_acc_b, n_writes;
    logic exp_ra, exp_rb;
    do_reset();
    next_a = 32'hA000_0000; next_b = 32'hB000_0000;
    n_acc_a = 0; n_acc_b = 0; n_writes = 0;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_reg = 5'd10; a_data = next_a;
      b_valid = 1; b_reg = 5'd20; b_data = next_b;
      // A takes the first two edges, then the ports take turns
      exp_ra = (i == 0) || (i % 2 == 1);
      exp_rb = (i % 2 == 0);
      n_checks++; if (a_ready !== exp_ra || b_ready !== exp_rb) begin n_fail++; $display("FAIL cont_ready[%0d]: got a=%0h b=%0h want a=%0h b=%0h", i, a_ready, b_ready, exp_ra, exp_rb); end
      if (exp_ra) begin exp_a.push_back(next_a); next_a++; n_acc_a++; end
      if (exp_rb) begin exp_b.push_back(next_b); next_b++; n_acc_b++; end
      tick();
      if (we) begin
        if (n_writes % 2 == 0) exp_q.push_back(exp_a.pop_front());
        else exp_q.push_back(exp_b.pop_front());
        n_checks++; if (wdata !== exp_q[0] || wreg !== ((n_writes % 2 == 0) ? 5'd10 : 5'd20)) begin n_fail++; $display("FAIL cont_write[%0d]: got reg=%0d data=%0h want data=%0h", n_writes, wreg, wdata, exp_q[0]); end
        void'(exp_q.pop_front());
        n_writes++;
      end
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (we) begin
        if (n_writes % 2 == 0) exp_q.push_back((exp_a.size() > 0) ? exp_a.pop_front() : 32'hDEAD);
        else exp_q.push_back((exp_b.size() > 0) ? exp_b.pop_front() : 32'hDEAD);
        n_checks++; if (wdata !== exp_q[0] || wreg !== ((n_writes % 2 == 0) ? 5'd10 : 5'd20)) begin n_fail++; $display("FAIL cont_drain[%0d]: got reg=%0d data=%0h want data=%0h", n_writes, wreg, wdata, exp_q[0]); end
        void'(exp_q.pop_front());
        n_writes++;
      end
    end
    n_checks++; if (n_writes != 9 || n_acc_a != 5 || n_acc_b != 4) begin n_fail++; $display("FAIL cont_count: got writes=%0d want 9", n_writes); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL cont_idle: got %0h want 1", idle); end
  endtask

  task automatic test_r0_discard();
    do_reset();
    b_valid = 1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %0h want 1", b_ready); end
    tick();
    idle_inputs();
    n_checks++; if (we !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL r0_accept: got we=%0h idle=%0h want 0/1", we, idle); end
    tick();
    n_checks++; if (we !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL r0_later: got we=%0h idle=%0h want 0/1", we, idle); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    a_valid = 1; a_reg = 5'd3; a_data = 32'h33;
    b_valid = 1; b_reg = 5'd4; b_data = 32'h44;
    tick();
    b_valid = 0; a_data = 32'h35;
    tick();
    idle_inputs();
    // A wrote, refilled; B still waiting: both buffers full
    n_checks++; if (we !== 1'b1 || wreg !== 5'd3 || conflicts !== 8'd1 || idle !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got we=%0h reg=%0d cnt=%0d idle=%0h want 1/3/1/0", we, wreg, conflicts, idle); end
    #2;
    ctrl_reset = 0;
    #1;
    n_checks++; if (we !== 1'b0 || wreg !== 5'd0 || wdata !== 32'd0 || conflicts !== 8'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL mid_async: got we=%0h reg=%0d data=%0h cnt=%0d idle=%0h want 0/0/0/0/1", we, wreg, wdata, conflicts, idle); end
    #4;
    ctrl_reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (we !== 1'b0 || idle !== 1'b1 || conflicts !== 8'd0) begin n_fail++; $display("FAIL mid_after[%0d]: got we=%0h idle=%0h cnt=%0d want 0/1/0", i, we, idle, conflicts); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a_valid = 1; a_reg = 5'd1; a_data = i;
      b_valid = 1; b_reg = 5'd2; b_data = i + 100;
      tick();
      // both buffers full from the second edge onward
      if (i >= 4) begin
        n_checks++; if (s_conflicts !== 2'd3) begin n_fail++; $display("FAIL sat_hold[%0d]: got %0d want 3", i, s_conflicts); end
      end
      n_checks++; if (conflicts !== 8'(i)) begin n_fail++; $display("FAIL sat_wide[%0d]: got %0d want %0d", i, conflicts, i); end
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    logic [36:0] qa[$];
    logic [36:0] qb[$];
    logic last_was_b, has_a, has_b, gnt_a, gnt_b, exp_ra, exp_rb;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_cnt;
    logic [36:0] e;
    do_reset();
    last_was_b = 1; m_we = 0; m_reg = 0; m_data = 0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      a_valid = ($urandom_range(0, 9) < 6);
      a_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a_data  = $urandom;
      b_valid = ($urandom_range(0, 9) < 6);
      b_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      b_data  = $urandom;
      has_a = (qa.size() != 0);
      has_b = (qb.size() != 0);
      // round robin: with both waiting, the port not served last goes first
      if (has_a && has_b) begin gnt_a = last_was_b; gnt_b = !last_was_b; end
      else begin gnt_a = has_a; gnt_b = has_b; end
      exp_ra = !has_a || gnt_a;
      exp_rb = !has_b || gnt_b;
      n_checks++; if (a_ready !== exp_ra || b_ready !== exp_rb) begin n_fail++; $display("FAIL rnd_ready[%0d]: got a=%0h b=%0h want a=%0h b=%0h", i, a_ready, b_ready, exp_ra, exp_rb); end
      m_we = 0;
      if (gnt_a) begin e = qa.pop_front(); m_we = 1; last_was_b = 0; {m_reg, m_data} = e; end
      if (gnt_b) begin e = qb.pop_front(); m_we = 1; last_was_b = 1; {m_reg, m_data} = e; end
      if (has_a && has_b) m_cnt++;
      if (a_valid && exp_ra && a_reg != 0) qa.push_back({a_reg, a_data});
      if (b_valid && exp_rb && b_reg != 0) qb.push_back({b_reg, b_data});
      tick();
      n_checks++; if (we !== m_we || wreg !== m_reg || wdata !== m_data) begin n_fail++; $display("FAIL rnd_write[%0d]: got %0h/%0d/%0h want %0h/%0d/%0h", i, we, wreg, wdata, m_we, m_reg, m_data); end
      n_checks++; if (conflicts !== 8'((m_cnt > 255) ? 255 : m_cnt) || s_conflicts !== 2'((m_cnt > 3) ? 3 : m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d", i, conflicts, s_conflicts, m_cnt); end
      n_checks++; if (idle !== (qa.size() == 0 && qb.size() == 0 && !m_we)) begin n_fail++; $display("FAIL rnd_idle[%0d]: got %0h", i, idle); end
    end
    idle_inputs();
  endtask

  // sequencer and final report
  initial begin
    idle_inputs();
    ctrl_reset = 0;
    test_reset();
    test_single_write();
    test_simultaneous();
    test_contention();
    test_r0_discard();
    test_reset_midflight();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
